// File: rtl/matrix_scanner.sv
// matrix_scanner: one-hot row driver for a keypad matrix with synchronised
// column sensing, press/release debounce, multi-key detection and auto-repeat.
module matrix_scanner #(
   parameter int NROWS           = 4,
   parameter int NCOLS           = 4,
   parameter int SETTLE_CYCLES   = 8,
   parameter int DEBOUNCE_CYCLES = 20000,
   parameter int REPEAT_DELAY    = 6000000,
   parameter int REPEAT_PERIOD   = 1200000
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NCOLS-1:0]               columns,
   input  logic                           repeat_en,
   output logic [NROWS-1:0]               rows,
   output logic [$clog2(NROWS*NCOLS)-1:0] key_code,
   output logic                           key_valid,
   output logic                           key_held,
   output logic                           multi_key
);

   localparam int KW      = $clog2(NROWS*NCOLS);
   localparam int RW      = $clog2(NROWS);
   localparam int CW      = $clog2(NCOLS);
   localparam int SW      = $clog2(SETTLE_CYCLES + 1);
   localparam int DW      = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int PW      = $clog2(REP_MAX + 1);
   localparam logic [NROWS-1:0] ROW_ONE = NROWS'(1);

   typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

   // Number of active (low) columns in a sampled pattern.
   function automatic logic [3:0] zero_count(input logic [NCOLS-1:0] p);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < NCOLS; i++) n = n + {3'b000, ~p[i]};
      return n;
   endfunction

   // Index of the lowest active (low) column in a sampled pattern.
   function automatic logic [CW-1:0] zero_index(input logic [NCOLS-1:0] p);
      logic [CW-1:0] idx;
      idx = '0;
      for (int i = NCOLS - 1; i >= 0; i--) if (!p[i]) idx = CW'(i);
      return idx;
   endfunction

   logic [NCOLS-1:0] r_sync1, r_col_s;
   logic [RW-1:0]    r_tag1, r_tag2;
   state_t           r_state, w_state;
   logic [RW-1:0]    r_row, w_row;
   logic [SW-1:0]    r_settle, w_settle;
   logic [DW-1:0]    r_cnt, w_cnt;
   logic [NCOLS-1:0] r_pattern, w_pattern;
   logic [PW-1:0]    r_rep, w_rep;
   logic             r_rep_armed, w_rep_armed;
   logic             r_single, w_single;
   logic [KW-1:0]    r_key_code, w_key_code;
   logic             r_key_valid, w_key_valid;
   logic             r_key_held, w_key_held;
   logic             r_multi, w_multi;

   logic             w_idle;
   logic             w_aligned;
   logic [RW-1:0]    w_row_next;
   logic [KW-1:0]    w_accept_code;

   // col_s reaches the FSM two cycles after the row that produced it was
   // driven, so the row index travels with it; r_tag2 names the row that
   // r_col_s actually belongs to.
   assign w_idle        = &r_col_s;
   assign w_aligned     = (r_tag2 == r_row);
   assign w_row_next    = (r_row == RW'(NROWS - 1)) ? '0 : r_row + RW'(1);
   assign w_accept_code = KW'(r_row) * KW'(NCOLS) + KW'(zero_index(r_pattern));

   assign rows      = ROW_ONE << r_row;
   assign key_code  = r_key_code;
   assign key_valid = r_key_valid;
   assign key_held  = r_key_held;
   assign multi_key = r_multi;

   // Two-flop column synchroniser plus the matching row-tag pipeline.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1 <= '1;
         r_col_s <= '1;
         r_tag1  <= '0;
         r_tag2  <= '0;
      end else begin
         r_sync1 <= columns;
         r_col_s <= r_sync1;
         r_tag1  <= r_row;
         r_tag2  <= r_tag1;
      end
   end

   // FSM and counter state register; reset also kills any pending pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= SCAN;
         r_row       <= '0;
         r_settle    <= '0;
         r_cnt       <= '0;
         r_pattern   <= '1;
         r_rep       <= '0;
         r_rep_armed <= 1'b0;
         r_single    <= 1'b0;
         r_key_code  <= '0;
         r_key_valid <= 1'b0;
         r_key_held  <= 1'b0;
         r_multi     <= 1'b0;
      end else begin
         r_state     <= w_state;
         r_row       <= w_row;
         r_settle    <= w_settle;
         r_cnt       <= w_cnt;
         r_pattern   <= w_pattern;
         r_rep       <= w_rep;
         r_rep_armed <= w_rep_armed;
         r_single    <= w_single;
         r_key_code  <= w_key_code;
         r_key_valid <= w_key_valid;
         r_key_held  <= w_key_held;
         r_multi     <= w_multi;
      end
   end

   // Next-state, counter and output-pulse logic.
   always_comb begin
      w_state     = r_state;
      w_row       = r_row;
      w_settle    = r_settle;
      w_cnt       = r_cnt;
      w_pattern   = r_pattern;
      w_rep       = r_rep;
      w_rep_armed = r_rep_armed;
      w_single    = r_single;
      w_key_code  = r_key_code;
      w_key_valid = 1'b0;
      w_key_held  = r_key_held;
      w_multi     = 1'b0;
      case (r_state)
         SCAN: begin
            if (r_settle == SW'(SETTLE_CYCLES - 1)) begin
               w_settle = '0;
               if (w_idle) begin
                  w_row = w_row_next;
               end else begin
                  // Re-select the row the low pattern really came from.
                  w_row     = r_tag2;
                  w_pattern = r_col_s;
                  w_cnt     = '0;
                  w_state   = DEBOUNCE;
               end
            end else begin
               w_settle = r_settle + SW'(1);
            end
         end
         DEBOUNCE: begin
            // Samples still in flight from another row are neither counted
            // nor treated as a mismatch.
            if (w_aligned) begin
               if (r_col_s != r_pattern) begin
                  w_state  = SCAN;
                  w_settle = '0;
               end else if (r_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                  w_state     = HELD;
                  w_cnt       = '0;
                  w_rep       = '0;
                  w_rep_armed = 1'b0;
                  if (zero_count(r_pattern) == 4'd1) begin
                     w_key_code  = w_accept_code;
                     w_key_valid = 1'b1;
                     w_key_held  = 1'b1;
                     w_single    = 1'b1;
                  end else begin
                     w_multi    = 1'b1;
                     w_key_held = 1'b0;
                     w_single   = 1'b0;
                  end
               end else begin
                  w_cnt = r_cnt + DW'(1);
               end
            end
         end
         HELD: begin
            if (w_idle) begin
               w_state = RELEASE;
               w_cnt   = '0;
            end else if (repeat_en && r_single) begin
               if (!r_rep_armed && r_rep == PW'(REPEAT_DELAY - 1)) begin
                  w_key_valid = 1'b1;
                  w_rep       = '0;
                  w_rep_armed = 1'b1;
               end else if (r_rep_armed && r_rep == PW'(REPEAT_PERIOD - 1)) begin
                  w_key_valid = 1'b1;
                  w_rep       = '0;
               end else begin
                  w_rep = r_rep + PW'(1);
               end
            end else begin
               w_rep       = '0;
               w_rep_armed = 1'b0;
            end
         end
         RELEASE: begin
            if (!w_idle) begin
               w_state = HELD;
               w_cnt   = '0;
            end else if (r_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
               w_state    = SCAN;
               w_key_held = 1'b0;
               w_single   = 1'b0;
               w_row      = w_row_next;
               w_settle   = '0;
               w_cnt      = '0;
            end else begin
               w_cnt = r_cnt + DW'(1);
            end
         end
         default: begin
            w_state  = SCAN;
            w_settle = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_matrix_scanner.sv
// tb_matrix_scanner: directed bench for matrix_scanner with a keypad model
// that pulls a column low only while the pressed key's row is driven.
module tb_matrix_scanner;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  columns;
   logic        repeat_en;
   logic [3:0]  rows;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_held;
   logic        multi_key;
   logic [15:0] keys_down;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   matrix_scanner #(
      .NROWS(4), .NCOLS(4), .SETTLE_CYCLES(2), .DEBOUNCE_CYCLES(4),
      .REPEAT_DELAY(10), .REPEAT_PERIOD(5)
   ) dut (
      .clk(clk), .reset(reset), .columns(columns), .repeat_en(repeat_en),
      .rows(rows), .key_code(key_code), .key_valid(key_valid),
      .key_held(key_held), .multi_key(multi_key)
   );

   // Keypad: key (r,c) pulls column c low while row r is driven.
   always_comb begin
      columns = 4'b1111;
      for (int rr = 0; rr < 4; rr++)
         for (int cc = 0; cc < 4; cc++)
            if (rows[rr] && keys_down[rr*4 + cc]) columns[cc] = 1'b0;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits for key_valid (want_multi=0) or multi_key (want_multi=1),
   // counting any pulses of the other kind seen on the way.
   task automatic wait_pulse(input bit want_multi, input int limit,
                             output bit found, output int other);
      found = 1'b0;
      other = 0;
      for (int i = 0; i < limit && !found; i++) begin
         if ((want_multi ? multi_key : key_valid) === 1'b1) found = 1'b1;
         else begin
            if ((want_multi ? key_valid : multi_key) === 1'b1) other++;
            tick();
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; keys_down = '0; repeat_en = 1'b0;
      tick(); tick();
      checks++; if (rows !== 4'b0001) begin errors++; $display("FAIL reset_rows got %b want 0001", rows); end
      checks++; if (key_code !== 4'd0) begin errors++; $display("FAIL reset_code got %0d want 0", key_code); end
      checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", key_valid); end
      checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL reset_held got %b want 0", key_held); end
      checks++; if (multi_key !== 1'b0) begin errors++; $display("FAIL reset_multi got %b want 0", multi_key); end
   endtask

   task automatic test_idle_scan();
      logic [3:0] exp;
      reset = 1'b0;
      for (int i = 0; i < 40; i++) begin
         exp = 4'(1 << ((i / 2) % 4));
         checks++; if (rows !== exp) begin errors++; $display("FAIL idle_rows cycle %0d got %b want %b", i, rows, exp); end
         checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL idle_valid cycle %0d got %b want 0", i, key_valid); end
         tick();
      end
   endtask

   task automatic test_clean_press();
      bit found; int other; int extra;
      keys_down = 16'h0200;                       // row 2, col 1
      wait_pulse(1'b0, 80, found, other);
      checks++; if (!found) begin errors++; $display("FAIL press_seen got none want key_valid within 80 cycles"); end
      checks++; if (key_code !== 4'd9) begin errors++; $display("FAIL press_code got %0d want 9", key_code); end
      checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL press_held got %b want 1", key_held); end
      checks++; if (other != 0) begin errors++; $display("FAIL press_multi got %0d pulses want 0", other); end
      tick();
      checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL press_pulse_width got %b want 0", key_valid); end
      extra = 0;
      for (int i = 0; i < 5; i++) begin tick(); if (key_valid === 1'b1) extra++; end
      checks++; if (extra != 0) begin errors++; $display("FAIL press_no_repeat got %0d pulses want 0", extra); end
      keys_down = '0;
      repeat (6) tick();
      checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL release_early got held=%b want 1", key_held); end
      tick();
      checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL release_held got %b want 0", key_held); end
      checks++; if (rows !== 4'b1000) begin errors++; $display("FAIL release_next_row got %b want 1000", rows); end
   endtask

   task automatic test_bounce();
      int pulses; bit found;
      for (int i = 0; i < 6; i++) begin
         keys_down[9] = (i % 2 == 0);
         checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL bounce_valid cycle %0d got %b want 0", i, key_valid); end
         tick();
      end
      keys_down[9] = 1'b1;
      for (int i = 0; i < 5; i++) begin
         checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL bounce_early cycle %0d got %b want 0", i, key_valid); end
         tick();
      end
      pulses = 0;
      for (int i = 0; i < 80; i++) begin
         if (key_valid === 1'b1) begin
            pulses++;
            checks++; if (key_code !== 4'd9) begin errors++; $display("FAIL bounce_code got %0d want 9", key_code); end
         end
         tick();
      end
      checks++; if (pulses != 1) begin errors++; $display("FAIL bounce_pulses got %0d want 1", pulses); end
      keys_down = '0;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin if (key_held === 1'b0) found = 1'b1; else tick(); end
      checks++; if (!found) begin errors++; $display("FAIL bounce_release got held=1 want 0 within 20 cycles"); end
   endtask

   task automatic test_multi_key();
      bit found; int other; int bad;
      keys_down = 16'h0006;                       // row 0, cols 1 and 2
      wait_pulse(1'b1, 80, found, other);
      checks++; if (!found) begin errors++; $display("FAIL multi_seen got none want multi_key within 80 cycles"); end
      checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL multi_with_valid got %b want 0", key_valid); end
      checks++; if (other != 0) begin errors++; $display("FAIL multi_valid_before got %0d pulses want 0", other); end
      checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL multi_held got %b want 0", key_held); end
      checks++; if (key_code !== 4'd9) begin errors++; $display("FAIL multi_code got %0d want 9", key_code); end
      tick();
      checks++; if (multi_key !== 1'b0) begin errors++; $display("FAIL multi_pulse_width got %b want 0", multi_key); end
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         if (rows !== 4'b0001 || key_valid !== 1'b0 || multi_key !== 1'b0) bad++;
         tick();
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL multi_hold got %0d bad cycles want 0", bad); end
      keys_down = '0;
      repeat (7) tick();
      checks++; if (rows !== 4'b0010) begin errors++; $display("FAIL multi_resume got %b want 0010", rows); end
      checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL multi_release_held got %b want 0", key_held); end
   endtask

   task automatic test_repeat();
      bit found; int other; logic exp;
      repeat_en = 1'b1;
      keys_down = 16'h0020;                       // row 1, col 1
      wait_pulse(1'b0, 80, found, other);
      checks++; if (!found) begin errors++; $display("FAIL repeat_press got none want key_valid within 80 cycles"); end
      checks++; if (key_code !== 4'd5) begin errors++; $display("FAIL repeat_code0 got %0d want 5", key_code); end
      for (int i = 1; i <= 27; i++) begin
         tick();
         exp = (i == 10 || i == 15 || i == 20 || i == 25);
         checks++; if (key_valid !== exp) begin errors++; $display("FAIL repeat_pulse at +%0d got %b want %b", i, key_valid, exp); end
         if (exp) begin
            checks++; if (key_code !== 4'd5) begin errors++; $display("FAIL repeat_code at +%0d got %0d want 5", i, key_code); end
         end
      end
      keys_down = '0;
      repeat_en = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin if (key_held === 1'b0) found = 1'b1; else tick(); end
      checks++; if (!found) begin errors++; $display("FAIL repeat_release got held=1 want 0 within 20 cycles"); end
   endtask

   task automatic test_reset_mid_debounce();
      int pulses;
      reset = 1'b1; keys_down = '0;
      tick();
      keys_down[0] = 1'b1;                        // row 0, col 0
      reset = 1'b0;
      repeat (7) tick();
      checks++; if (key_valid !== 1'b0 || key_held !== 1'b0) begin errors++; $display("FAIL mid_pre_reset got valid=%b held=%b want 0 0", key_valid, key_held); end
      reset = 1'b1;
      tick();
      checks++; if (rows !== 4'b0001) begin errors++; $display("FAIL mid_rows got %b want 0001", rows); end
      checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b want 0", key_valid); end
      checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL mid_held got %b want 0", key_held); end
      checks++; if (multi_key !== 1'b0) begin errors++; $display("FAIL mid_multi got %b want 0", multi_key); end
      checks++; if (key_code !== 4'd0) begin errors++; $display("FAIL mid_code got %0d want 0", key_code); end
      keys_down = '0;
      tick();
      reset = 1'b0;
      pulses = 0;
      for (int i = 0; i < 30; i++) begin
         if (key_valid === 1'b1 || key_held === 1'b1) pulses++;
         tick();
      end
      checks++; if (pulses != 0) begin errors++; $display("FAIL mid_after got %0d active cycles want 0", pulses); end
   endtask

   initial begin
      test_reset();
      test_idle_scan();
      test_clean_press();
      test_bounce();
      test_multi_key();
      test_repeat();
      test_reset_mid_debounce();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got still running want finished");
      $fatal(1, "watchdog expired");
   end

endmodule
